// File: rtl/uart_decoder.sv
// uart_decoder: UART receiver with 16x oversampling, an echo transmitter and
// a small command decoder driving pattern/mode/start/stop control outputs.
//
// Ports:
//   clk, rst_n          system clock (rising edge), async active-low reset
//   i_rx                serial input, idle high
//   o_tx                serial echo output, idle high
//   o_rx_done_tick      one-cycle pulse, o_rx_data holds a new byte
//   o_rx_data           last received byte
//   o_tx_done_tick      one-cycle pulse at the end of an echo frame
//   o_output_pattern    pattern register loaded by command 0x01
//   o_freq_pattern      pattern register loaded by command 0x02
//   o_mode              set by 0x03, cleared by 0x04
//   o_start, o_stop     one-cycle pulses from 0x05 / 0x06
//   o_done_tick         one-cycle pulse when a valid command completes
//
// FSM states:
//   RX_IDLE  | waiting for a falling edge on the line
//   RX_START | checking the start bit at mid-bit
//   RX_DATA  | sampling data bits LSB first
//   RX_STOP  | waiting out the stop bit
//   TX_*     | same framing on the transmit side
//   D_CMD    | next byte is a command
//   D_LO     | next byte is a pattern low byte
//   D_HI     | next byte is a pattern high byte
module uart_decoder #(
  parameter int SYS_CLK   = 10_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int STOP_TICK = 16,
  parameter int CLK_DIV   = 65,
  parameter int DIV_BIT   = 7,
  parameter int DATA_BIT  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx,
  output logic                 o_tx,
  output logic                 o_rx_done_tick,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_tx_done_tick,
  output logic [DATA_BIT-1:0]  o_output_pattern,
  output logic [DATA_BIT-1:0]  o_freq_pattern,
  output logic                 o_mode,
  output logic                 o_start,
  output logic                 o_stop,
  output logic                 o_done_tick
);

  // A zero CLK_DIV falls back to the divider implied by the clock and baud.
  localparam int DIV = (CLK_DIV > 0) ? CLK_DIV : SYS_CLK / (16 * BAUD_RATE);
  localparam int NW  = $clog2(DATA_BITS + 1);
  localparam int TW  = 8;

  // ---------------- oversample tick ----------------
  logic [DIV_BIT-1:0] div_q;
  logic               tick;

  assign tick = (div_q == DIV_BIT'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  // Two-flop synchronizer; resets to the idle level so reset is not a start bit.
  logic [1:0] rx_sync;
  logic       rx_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], i_rx};
  end
  assign rx_in = rx_sync[1];

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t            rx_q, rx_d;
  logic [TW-1:0]        rs_q, rs_d;
  logic [NW-1:0]        rn_q, rn_d;
  logic [DATA_BITS-1:0] rb_q, rb_d, rdata_d;
  logic                 rdone_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q <= RX_IDLE; rs_q <= '0; rn_q <= '0; rb_q <= '0;
      o_rx_done_tick <= 1'b0; o_rx_data <= '0;
    end else begin
      rx_q <= rx_d; rs_q <= rs_d; rn_q <= rn_d; rb_q <= rb_d;
      o_rx_done_tick <= rdone_d; o_rx_data <= rdata_d;
    end
  end

  always_comb begin
    rx_d = rx_q; rs_d = rs_q; rn_d = rn_q; rb_d = rb_q;
    rdone_d = 1'b0; rdata_d = o_rx_data;
    case (rx_q)
      RX_IDLE: if (!rx_in) begin rx_d = RX_START; rs_d = '0; end
      RX_START: if (tick) begin
        if (rs_q == TW'(7)) begin
          rs_d = '0; rn_d = '0;
          rx_d = rx_in ? RX_IDLE : RX_DATA;   // a short glitch is dropped here
        end else rs_d = rs_q + 1'b1;
      end
      RX_DATA: if (tick) begin
        if (rs_q == TW'(15)) begin
          rs_d = '0;
          rb_d = {rx_in, rb_q[DATA_BITS-1:1]};
          if (rn_q == NW'(DATA_BITS - 1)) rx_d = RX_STOP;
          else rn_d = rn_q + 1'b1;
        end else rs_d = rs_q + 1'b1;
      end
      RX_STOP: if (tick) begin
        if (rs_q == TW'(STOP_TICK - 1)) begin
          rx_d = RX_IDLE; rdone_d = 1'b1; rdata_d = rb_q;
        end else rs_d = rs_q + 1'b1;
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // ---------------- echo transmitter ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  tx_state_t            tx_q, tx_d;
  logic [TW-1:0]        ts_q, ts_d;
  logic [NW-1:0]        tn_q, tn_d;
  logic [DATA_BITS-1:0] tb_q, tb_d;
  logic                 txo_d, tdone_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= TX_IDLE; ts_q <= '0; tn_q <= '0; tb_q <= '0;
      o_tx <= 1'b1; o_tx_done_tick <= 1'b0;
    end else begin
      tx_q <= tx_d; ts_q <= ts_d; tn_q <= tn_d; tb_q <= tb_d;
      o_tx <= txo_d; o_tx_done_tick <= tdone_d;
    end
  end

  always_comb begin
    tx_d = tx_q; ts_d = ts_q; tn_d = tn_q; tb_d = tb_q;
    tdone_d = 1'b0;
    case (tx_q)
      // Requests only land in idle, so a byte arriving mid-frame is dropped.
      TX_IDLE: if (o_rx_done_tick) begin
        tx_d = TX_START; ts_d = '0; tb_d = o_rx_data;
      end
      TX_START: if (tick) begin
        if (ts_q == TW'(15)) begin tx_d = TX_DATA; ts_d = '0; tn_d = '0; end
        else ts_d = ts_q + 1'b1;
      end
      TX_DATA: if (tick) begin
        if (ts_q == TW'(15)) begin
          ts_d = '0;
          tb_d = tb_q >> 1;
          if (tn_q == NW'(DATA_BITS - 1)) tx_d = TX_STOP;
          else tn_d = tn_q + 1'b1;
        end else ts_d = ts_q + 1'b1;
      end
      TX_STOP: if (tick) begin
        if (ts_q == TW'(STOP_TICK - 1)) begin tx_d = TX_IDLE; tdone_d = 1'b1; end
        else ts_d = ts_q + 1'b1;
      end
      default: tx_d = TX_IDLE;
    endcase
    // Line level follows the next state so o_tx is registered without lag.
    case (tx_d)
      TX_START: txo_d = 1'b0;
      TX_DATA:  txo_d = tb_d[0];
      default:  txo_d = 1'b1;
    endcase
  end

  // ---------------- command decoder ----------------
  typedef enum logic [1:0] {D_CMD, D_LO, D_HI} dec_state_t;
  dec_state_t           dec_q, dec_d;
  logic                 sel_q, sel_d;
  logic [DATA_BITS-1:0] lo_q, lo_d;
  logic [DATA_BIT-1:0]  op_d, fp_d;
  logic                 mode_d, start_d, stop_d, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= D_CMD; sel_q <= 1'b0; lo_q <= '0;
      o_output_pattern <= '0; o_freq_pattern <= '0; o_mode <= 1'b0;
      o_start <= 1'b0; o_stop <= 1'b0; o_done_tick <= 1'b0;
    end else begin
      dec_q <= dec_d; sel_q <= sel_d; lo_q <= lo_d;
      o_output_pattern <= op_d; o_freq_pattern <= fp_d; o_mode <= mode_d;
      o_start <= start_d; o_stop <= stop_d; o_done_tick <= done_d;
    end
  end

  always_comb begin
    dec_d = dec_q; sel_d = sel_q; lo_d = lo_q;
    op_d = o_output_pattern; fp_d = o_freq_pattern; mode_d = o_mode;
    start_d = 1'b0; stop_d = 1'b0; done_d = 1'b0;
    if (o_rx_done_tick) begin
      case (dec_q)
        D_CMD: case (o_rx_data)
          DATA_BITS'(8'h01): begin dec_d = D_LO; sel_d = 1'b0; end
          DATA_BITS'(8'h02): begin dec_d = D_LO; sel_d = 1'b1; end
          DATA_BITS'(8'h03): begin mode_d  = 1'b1; done_d = 1'b1; end
          DATA_BITS'(8'h04): begin mode_d  = 1'b0; done_d = 1'b1; end
          DATA_BITS'(8'h05): begin start_d = 1'b1; done_d = 1'b1; end
          DATA_BITS'(8'h06): begin stop_d  = 1'b1; done_d = 1'b1; end
          default: ;
        endcase
        D_LO: begin lo_d = o_rx_data; dec_d = D_HI; end
        D_HI: begin
          // Low byte was staged, so the register jumps straight to the new value.
          if (sel_q) fp_d = DATA_BIT'({o_rx_data, lo_q});
          else       op_d = DATA_BIT'({o_rx_data, lo_q});
          done_d = 1'b1;
          dec_d  = D_CMD;
        end
        default: dec_d = D_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_decoder.sv
`timescale 1ns/1ps
module tb_uart_decoder;

  localparam int FDIV  = 4;           // fast instance: 4 clocks per tick
  localparam int FBIT  = 16 * FDIV;   // 64 clocks per bit
  localparam int DBIT_RX = 1042;      // 10 MHz / 9600 baud
  localparam int DBIT_TX = 16 * 65;   // default-instance transmit bit period

  logic clk = 1'b0;
  always #50 clk = ~clk;              // 10 MHz

  // fast instance
  logic        rst_n = 1'b0, rx = 1'b1;
  logic        tx, rxd, txd, mode, start, stop, done;
  logic [7:0]  rxdat;
  logic [15:0] op, fp;

  // default-parameter instance
  logic        rst_dn = 1'b0, rx_dl = 1'b1;
  logic        tx_dl, rxd_dl, txd_dl, mode_dl, start_dl, stop_dl, done_dl;
  logic [7:0]  rxdat_dl;
  logic [15:0] op_dl, fp_dl;

  uart_decoder #(.SYS_CLK(10_000_000), .BAUD_RATE(156_250), .DATA_BITS(8),
                 .STOP_TICK(16), .CLK_DIV(FDIV), .DIV_BIT(3), .DATA_BIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx(rx), .o_tx(tx), .o_rx_done_tick(rxd),
    .o_rx_data(rxdat), .o_tx_done_tick(txd), .o_output_pattern(op),
    .o_freq_pattern(fp), .o_mode(mode), .o_start(start), .o_stop(stop),
    .o_done_tick(done));

  uart_decoder dut_def (
    .clk(clk), .rst_n(rst_dn), .i_rx(rx_dl), .o_tx(tx_dl), .o_rx_done_tick(rxd_dl),
    .o_rx_data(rxdat_dl), .o_tx_done_tick(txd_dl), .o_output_pattern(op_dl),
    .o_freq_pattern(fp_dl), .o_mode(mode_dl), .o_start(start_dl), .o_stop(stop_dl),
    .o_done_tick(done_dl));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the command stream ----------------
  logic [7:0]  rx_q[$];     // bytes on the wire not yet reported received
  logic [7:0]  echo_q[$];   // bytes whose echo is still expected
  int          m_phase = 0; // 0: expect command, 1: low byte, 2: high byte
  bit          m_tgt = 0;   // 0: output pattern, 1: freq pattern
  logic [7:0]  m_lo = '0;
  logic [15:0] m_op = '0, m_fp = '0;
  logic        m_mode = 1'b0, e_start, e_stop, e_done;
  bit          pend = 0;
  logic [7:0]  pend_b;
  int n_sent = 0, n_rxd = 0, n_txd = 0, n_done = 0, n_start = 0, n_stop = 0;

  task automatic model_step(input logic [7:0] b);
    case (m_phase)
      0: case (b)
           8'h01: begin m_phase = 1; m_tgt = 0; end
           8'h02: begin m_phase = 1; m_tgt = 1; end
           8'h03: begin m_mode = 1'b1; e_done = 1'b1; end
           8'h04: begin m_mode = 1'b0; e_done = 1'b1; end
           8'h05: begin e_start = 1'b1; e_done = 1'b1; end
           8'h06: begin e_stop = 1'b1; e_done = 1'b1; end
           default: ;
         endcase
      1: begin m_lo = b; m_phase = 2; end
      default: begin
        if (m_tgt) m_fp = {b, m_lo}; else m_op = {b, m_lo};
        e_done = 1'b1;
        m_phase = 0;
      end
    endcase
  endtask

  // Compare process: every cycle, fast instance against the model.
  initial begin : cmp
    forever begin
      @(negedge clk);
      e_start = 1'b0; e_stop = 1'b0; e_done = 1'b0;
      if (!rst_n) begin
        m_phase = 0; m_op = '0; m_fp = '0; m_mode = 1'b0; pend = 0;
        rx_q.delete();
        chk("rst_tx", tx, 1); chk("rst_rx_done", rxd, 0); chk("rst_rx_data", rxdat, 0);
        chk("rst_tx_done", txd, 0); chk("rst_op", op, 0); chk("rst_fp", fp, 0);
        chk("rst_mode", mode, 0); chk("rst_start", start, 0); chk("rst_stop", stop, 0);
        chk("rst_done", done, 0);
      end else begin
        if (pend) begin model_step(pend_b); pend = 0; end
        chk("op", op, m_op); chk("fp", fp, m_fp); chk("mode", mode, m_mode);
        chk("start", start, e_start); chk("stop", stop, e_stop); chk("done", done, e_done);
        if (start) n_start++;
        if (stop)  n_stop++;
        if (done)  n_done++;
        if (txd)   n_txd++;
        if (rxd) begin
          n_rxd++;
          chk("rx_done_expected", rx_q.size() > 0, 1);
          if (rx_q.size() > 0) begin
            chk("rx_data", rxdat, rx_q[0]);
            pend_b = rx_q.pop_front();
            pend = 1;
          end
        end
      end
    end
  end

  // Echo monitor: decode o_tx of the fast instance at mid-bit.
  initial begin : echo_mon
    logic [7:0] eb;
    logic s0, s1;
    forever begin
      @(negedge tx);
      if (rst_n) begin
        repeat (FBIT / 2) @(posedge clk); #1 s0 = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (FBIT) @(posedge clk); #1 eb[i] = tx;
        end
        repeat (FBIT) @(posedge clk); #1 s1 = tx;
        chk("echo_start_bit", s0, 0);
        chk("echo_stop_bit", s1, 1);
        chk("echo_expected", echo_q.size() > 0, 1);
        if (echo_q.size() > 0) chk("echo_byte", eb, echo_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_q.push_back(b); echo_q.push_back(b); n_sent++;
    rx = 1'b0;
    repeat (FBIT) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (FBIT) @(posedge clk); #1;
    end
    rx = 1'b1;
    repeat (3 * FBIT) @(posedge clk); #1;   // stop bit plus two idle bits
    chk("rx_done_seen", rx_q.size(), 0);
  endtask

  // ---------------- default-parameter instance: 0xA5 at 9600 baud ----------------
  int  n_rxd_dl = 0, n_txd_dl = 0;
  logic [7:0] last_dl = '0;
  bit  def_done = 0;

  initial begin : def_cnt
    forever begin
      @(negedge clk);
      if (rst_dn && rxd_dl) begin n_rxd_dl++; last_dl = rxdat_dl; end
      if (rst_dn && txd_dl) n_txd_dl++;
    end
  end

  initial begin : def_test
    logic [7:0] d = 8'hA5, eb;
    logic s0, s1;
    int k;
    repeat (3) @(posedge clk); #1;
    chk("def_rst_tx", tx_dl, 1); chk("def_rst_rx_data", rxdat_dl, 0);
    chk("def_rst_op", op_dl, 0);
    rst_dn = 1'b1;
    repeat (5) @(posedge clk); #1;
    fork
      begin
        rx_dl = 1'b0; repeat (DBIT_RX) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin rx_dl = d[i]; repeat (DBIT_RX) @(posedge clk); #1; end
        rx_dl = 1'b1;
      end
      begin
        k = 0;
        while (tx_dl === 1'b1 && k < 30000) begin @(posedge clk); #1; k++; end
        chk("def_echo_timeout", k < 30000, 1);
        repeat (DBIT_TX / 2 - 1) @(posedge clk); #1 s0 = tx_dl;
        for (int i = 0; i < 8; i++) begin repeat (DBIT_TX) @(posedge clk); #1 eb[i] = tx_dl; end
        repeat (DBIT_TX) @(posedge clk); #1 s1 = tx_dl;
        chk("def_echo_start", s0, 0); chk("def_echo_byte", eb, 8'hA5); chk("def_echo_stop", s1, 1);
        k = 0;
        while (n_txd_dl == 0 && k < 3000) begin @(posedge clk); #1; k++; end
        chk("def_tx_done_cnt", n_txd_dl, 1);
      end
    join
    chk("def_rx_done_cnt", n_rxd_dl, 1);
    chk("def_rx_data", last_dl, 8'hA5);
    chk("def_rx_data_out", rxdat_dl, 8'hA5);
    chk("def_no_cmd", {op_dl, fp_dl, mode_dl, start_dl, stop_dl, done_dl}, 0);
    def_done = 1;
  end

  // ---------------- main sequence on the fast instance ----------------
  initial begin : main
    int c0, c1, c2;
    int k;
    repeat (5) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;

    send_byte(8'hA5);
    chk("lit_rx_a5", rxdat, 8'hA5);
    chk("lit_rx_cnt_1", n_rxd, 1);

    c0 = n_done;
    send_byte(8'h01); send_byte(8'h34);
    chk("lit_op_hold", op, 16'h0000);
    chk("lit_done_none_yet", n_done - c0, 0);
    send_byte(8'h12);
    chk("lit_op_1234", op, 16'h1234);
    chk("model_op_1234", m_op, 16'h1234);
    chk("lit_done_1", n_done - c0, 1);

    c0 = n_done;
    send_byte(8'h02); send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h03);
    chk("lit_fp_abcd", fp, 16'hABCD);
    chk("model_fp_abcd", m_fp, 16'hABCD);
    chk("lit_mode_1", mode, 1);
    chk("lit_done_2", n_done - c0, 2);

    c0 = n_done; c1 = n_start; c2 = n_stop;
    send_byte(8'h05);
    chk("lit_start_1", n_start - c1, 1);
    chk("lit_stop_0", n_stop - c2, 0);
    send_byte(8'h06);
    chk("lit_stop_1", n_stop - c2, 1);
    chk("lit_done_ss", n_done - c0, 2);

    c0 = n_done;
    send_byte(8'h7E);
    chk("lit_7e_ignored", n_done - c0, 0);
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'h00);
    chk("lit_op_00ff", op, 16'h00FF);
    chk("lit_done_7e", n_done - c0, 1);

    c0 = n_rxd;
    rx = 1'b0; repeat (3) @(posedge clk); #1 rx = 1'b1;
    repeat (2 * FBIT) @(posedge clk); #1;
    chk("lit_glitch_no_rx", n_rxd - c0, 0);

    send_byte(8'h01); send_byte(8'h34);
    repeat (12 * FBIT) @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("lit_rst_op", op, 0); chk("lit_rst_fp", fp, 0); chk("lit_rst_mode", mode, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    c0 = n_start; c1 = n_done;
    send_byte(8'h05);
    chk("lit_post_rst_start", n_start - c0, 1);
    chk("lit_post_rst_done", n_done - c1, 1);
    chk("lit_post_rst_op", op, 0);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) < 6) send_byte(8'($urandom_range(1, 6)));
      else                          send_byte(8'($urandom_range(0, 255)));
    end

    repeat (12 * FBIT) @(posedge clk); #1;
    chk("echo_all_seen", echo_q.size(), 0);
    chk("tx_done_cnt", n_txd, n_sent);
    chk("rx_done_cnt", n_rxd, n_sent);

    k = 0;
    while (!def_done && k < 40000) begin @(posedge clk); #1; k++; end
    chk("def_test_finished", def_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_decoder.md
UART_DECODER -- requirements
Module: uart_decoder

Interface
REQ-001 SHALL have parameter SYS_CLK, default 10_000_000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, UART data bits per frame.
REQ-004 SHALL have parameter STOP_TICK, default 16, oversample ticks for the stop bit (16 = 1 stop bit).
REQ-005 SHALL have parameter CLK_DIV, default 65, clocks per oversample tick (SYS_CLK/(16*BAUD_RATE)).
REQ-006 SHALL have parameter DIV_BIT, default 7, tick-divider counter width, at least log2(CLK_DIV).
REQ-007 SHALL have parameter DATA_BIT, default 16, pattern register width.
REQ-008 SHALL use one clock and an asynchronous active-low reset, with ports as follows.
REQ-009 clk  in  1  system clock, all logic on rising edge.
REQ-010 rst_n  in  1  asynchronous active-low reset.
REQ-011 i_rx  in  1  UART serial input, idle high.
REQ-012 o_tx  out  1  UART serial output, idle high, echo of received bytes.
REQ-013 o_rx_done_tick  out  1  one-cycle pulse, received byte valid.
REQ-014 o_rx_data  out  DATA_BITS  last received byte.
REQ-015 o_tx_done_tick  out  1  one-cycle pulse, echo frame finished.
REQ-016 o_output_pattern  out  DATA_BIT  output pattern register.
REQ-017 o_freq_pattern  out  DATA_BIT  frequency pattern register.
REQ-018 o_mode  out  1  mode register.
REQ-019 o_start  out  1  one-cycle start pulse.
REQ-020 o_stop  out  1  one-cycle stop pulse.
REQ-021 o_done_tick  out  1  one-cycle pulse, command complete.

Function
REQ-022 Tick generator SHALL count 0..CLK_DIV-1 and assert a one-clock tick at wrap.
REQ-023 RX FSM SHALL use states IDLE, START, DATA, STOP. On i_rx low in IDLE, go to START.
REQ-024 In START, at tick 7 (mid-bit), RX SHALL go to DATA if i_rx is still low, otherwise return to IDLE (glitch rejection).
REQ-025 In DATA, RX SHALL sample every 16 ticks and shift LSB first, DATA_BITS samples total.
REQ-026 RX SHALL wait STOP_TICK ticks in STOP, then load o_rx_data and pulse o_rx_done_tick for one clock. The stop-bit value SHALL NOT be checked.
REQ-027 TX SHALL start a frame on o_rx_done_tick with o_rx_data: start bit 0, data LSB first, stop bit 1. Each bit SHALL last 16 ticks; the stop bit SHALL last STOP_TICK ticks.
REQ-028 TX SHALL pulse o_tx_done_tick at frame end. A start request while TX is busy SHALL be dropped.
REQ-029 Decoder SHALL process one byte per o_rx_done_tick using states CMD, DATA_LO, DATA_HI.
REQ-030 Decoder commands:
- 0x01: next two bytes (low byte first) load o_output_pattern.
- 0x02: next two bytes (low byte first) load o_freq_pattern.
- 0x03: o_mode <= 1.
- 0x04: o_mode <= 0.
- 0x05: pulse o_start.
- 0x06: pulse o_stop.
- Any other command byte SHALL be ignored; decoder stays in CMD with no pulse.
REQ-031 A pattern register SHALL update only when its high byte arrives. Both bytes SHALL be staged, so the register changes atomically.
REQ-032 o_done_tick SHALL pulse one clock after the byte that completes a valid command, coincident with the register update or the o_start/o_stop pulse.
REQ-033 o_start, o_stop and o_done_tick SHALL be high for exactly one clock. All decoder outputs SHALL be registered.

Reset
REQ-034 rst_n low SHALL immediately force: o_tx=1, all ticks and pulses 0, o_rx_data=0, both patterns 0, o_mode=0, all FSMs to IDLE/CMD, tick counter 0.
REQ-035 Reset mid-frame or mid-command SHALL abandon the partial byte or command. No pulse SHALL be produced.

Verification
REQ-036 Bench setup: 10 MHz clock, BAUD 9600 frames (bit period 1042 clk). Send 0xA5 -> o_rx_data=0xA5, one o_rx_done_tick, identical frame echoed on o_tx, then o_tx_done_tick.
REQ-037 Send 0x01,0x34,0x12 -> o_output_pattern=0x1234 and one o_done_tick after the third byte. Value SHALL stay 0 until then.
REQ-038 Send 0x02,0xCD,0xAB, then 0x03 -> o_freq_pattern=0xABCD and o_mode=1. Two o_done_tick pulses.
REQ-039 Send 0x05, then 0x06 -> one o_start pulse, then one o_stop pulse, each one clock wide, each with o_done_tick.
REQ-040 Send 0x7E, then 0x01,0xFF,0x00 -> 0x7E ignored with no pulse; o_output_pattern=0x00FF.
REQ-041 Drop i_rx low for 3 clocks only -> no o_rx_done_tick. Assert rst_n low after 0x01,0x34 -> patterns 0, and next byte 0x05 is parsed as a command.
